// File: rtl/lsu_pkg.sv
// Shared encodings and helpers for the load/store unit.
package lsu_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_ILL  = 2'b11;

   typedef enum logic [1:0] {
      StIdle,
      StRd,
      StWr,
      StResp
   } lsu_state_e;

   // True for an illegal size or an address not aligned to the access size.
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
      logic bad;
      case (size)
         SZ_BYTE: bad = 1'b0;
         SZ_HALF: bad = lane[0];
         SZ_WORD: bad = (lane != 2'b00);
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Little-endian lane steering: load extraction/extension and sub-word store merge.
module lsu_lane_align
   import lsu_pkg::*;
(
   input  logic [31:0] ld_word_i,
   input  logic [1:0]  size_i,
   input  logic [1:0]  lane_i,
   input  logic        unsigned_i,
   output logic [31:0] ld_data_o,
   input  logic [31:0] st_old_i,
   input  logic [31:0] st_wdata_i,
   output logic [31:0] st_merged_o
);

   logic [7:0]  ld_byte;
   logic [15:0] ld_half;

   always_comb begin
      ld_byte   = ld_word_i[{lane_i, 3'b000} +: 8];
      ld_half   = ld_word_i[{lane_i[1], 4'b0000} +: 16];
      ld_data_o = ld_word_i;
      case (size_i)
         SZ_BYTE: ld_data_o = {{24{~unsigned_i & ld_byte[7]}}, ld_byte};
         SZ_HALF: ld_data_o = {{16{~unsigned_i & ld_half[15]}}, ld_half};
         default: ld_data_o = ld_word_i;
      endcase
   end

   always_comb begin
      st_merged_o = st_old_i;
      case (size_i)
         SZ_BYTE: st_merged_o[{lane_i, 3'b000} +: 8]     = st_wdata_i[7:0];
         SZ_HALF: st_merged_o[{lane_i[1], 4'b0000} +: 16] = st_wdata_i[15:0];
         default: st_merged_o = st_wdata_i;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit in front of a negedge word memory.
// Sub-word stores are read-modify-write through a one-word write buffer.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int unsigned MEM_ADDR_W = 32,
   parameter int unsigned WIDTH      = 32
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [1:0]            req_size,
   input  logic                  req_unsigned,
   input  logic [31:0]           req_addr,
   input  logic [WIDTH-1:0]      req_wdata,
   output logic                  resp_valid,
   output logic [WIDTH-1:0]      resp_rdata,
   output logic                  resp_error,
   output logic [MEM_ADDR_W-1:0] mem_address,
   output logic                  mem_writeEnable,
   output logic [WIDTH-1:0]      mem_dataIn,
   input  logic [WIDTH-1:0]      mem_dataOut
);

   lsu_state_e            state_q;
   logic                  write_q;
   logic [1:0]            size_q;
   logic                  unsigned_q;
   logic [MEM_ADDR_W+1:0] addr_q;
   logic [WIDTH-1:0]      wbuf_q;
   logic [WIDTH-1:0]      rdata_q;
   logic                  error_q;

   logic [31:0] ld_data;
   logic [31:0] st_merged;

   lsu_lane_align u_lane_align (
      .ld_word_i   (mem_dataOut),
      .size_i      (size_q),
      .lane_i      (addr_q[1:0]),
      .unsigned_i  (unsigned_q),
      .ld_data_o   (ld_data),
      .st_old_i    (mem_dataOut),
      .st_wdata_i  (wbuf_q),
      .st_merged_o (st_merged)
   );

   // Outputs decode the state register so reset drops the write strobe immediately.
   assign req_ready       = (state_q == StIdle);
   assign resp_valid      = (state_q == StResp);
   assign mem_writeEnable = (state_q == StWr);
   assign mem_address     = addr_q[MEM_ADDR_W+1:2];
   assign mem_dataIn      = wbuf_q;
   assign resp_rdata      = rdata_q;
   assign resp_error      = error_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= StIdle;
         write_q    <= 1'b0;
         size_q     <= 2'b00;
         unsigned_q <= 1'b0;
         addr_q     <= '0;
         wbuf_q     <= '0;
         rdata_q    <= '0;
         error_q    <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (req_valid) begin
                  write_q    <= req_write;
                  size_q     <= req_size;
                  unsigned_q <= req_unsigned;
                  addr_q     <= (MEM_ADDR_W+2)'(req_addr);
                  wbuf_q     <= req_wdata;
                  if (is_misaligned(req_size, req_addr[1:0])) begin
                     rdata_q <= '0;
                     error_q <= 1'b1;
                     state_q <= StResp;
                  end else if (req_write && (req_size == SZ_WORD)) begin
                     state_q <= StWr;
                  end else begin
                     state_q <= StRd;
                  end
               end
            end
            StRd: begin
               // mem_dataOut now holds the word latched on the preceding negedge.
               if (write_q) begin
                  wbuf_q  <= st_merged;
                  state_q <= StWr;
               end else begin
                  rdata_q <= ld_data;
                  error_q <= 1'b0;
                  state_q <= StResp;
               end
            end
            StWr: begin
               rdata_q <= '0;
               error_q <= 1'b0;
               state_q <= StResp;
            end
            StResp: begin
               state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule
